// File: rtl/tile_spawner.sv
// tile_spawner: places one new tile (exponent 1, or 2 with TILE_FOUR_EN defined)
// into a random empty cell of a 4x4 board, probing forward from a random start.
// Ports: clk, rst (async, active-high); spawn_req, board[63:0], rand_in[31:0] in;
// busy, board_we, board_wr_idx[3:0], board_wr_val[3:0], spawn_done, board_full out.
// Optional build macro: TILE_FOUR_EN (enables the exponent-2 tile).
module tile_spawner (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn_req,
    input  logic [63:0] board,
    input  logic [31:0] rand_in,
    output logic        busy,
    output logic        board_we,
    output logic [3:0]  board_wr_idx,
    output logic [3:0]  board_wr_val,
    output logic        spawn_done,
    output logic        board_full
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    logic [1:0]  state;
    logic [15:0] board_empty;
    logic [15:0] empty_mask;
    logic [3:0]  idx;
    logic [3:0]  skip_cnt;
    logic [3:0]  tile_val;
    logic        unused_bits;

    always_comb begin
        board_empty = '0;
        for (int i = 0; i < 16; i++) begin
            board_empty[i] = (board[4*i +: 4] == 4'd0);
        end
    end

`ifdef TILE_FOUR_EN
    logic [3:0] val_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_sel <= 4'd0;
        end else if (state == S_IDLE && spawn_req) begin
            val_sel <= rand_in[11:8];
        end
    end

    assign tile_val    = (val_sel == 4'd0) ? 4'd2 : 4'd1;
    assign unused_bits = ^{rand_in[31:12], rand_in[7:4]};
`else
    assign tile_val    = 4'd1;
    assign unused_bits = ^{rand_in[31:12], rand_in[11:4]};
`endif

    assign busy       = (state != S_IDLE);
    assign board_we   = (state == S_WRITE);
    assign spawn_done = (state == S_WRITE) || (state == S_FULL);

    // The empty test uses the mask captured at acceptance, so the FULL
    // verdict is taken in the first SCAN cycle and never probes a cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            empty_mask   <= '0;
            idx          <= 4'd0;
            skip_cnt     <= 4'd0;
            board_wr_idx <= 4'd0;
            board_wr_val <= 4'd0;
            board_full   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (spawn_req) begin
                        empty_mask <= board_empty;
                        idx        <= rand_in[3:0];
                        skip_cnt   <= 4'd0;
                        state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (empty_mask == 16'd0) begin
                        board_full <= 1'b1;
                        state      <= S_FULL;
                    end else if (empty_mask[idx]) begin
                        board_wr_idx <= idx;
                        board_wr_val <= tile_val;
                        board_full   <= 1'b0;
                        state        <= S_WRITE;
                    end else if (skip_cnt != 4'd15) begin
                        idx      <= idx + 4'd1;
                        skip_cnt <= skip_cnt + 4'd1;
                    end else begin
                        // Unreachable with a non-empty mask; bail out
                        // rather than wrap the skip counter.
                        board_full <= 1'b1;
                        state      <= S_FULL;
                    end
                end
                S_WRITE: state <= S_IDLE;
                S_FULL:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
